mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file: operands come from its two read ports (rd1 -> src_a, rd2 -> src_b).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and raises busy so control can stall the pipeline.
- Serves MTHI/MTLO writes. HI/LO are read combinationally for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only when busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  multiplicand/dividend (from register-file rd1).
- src_b  input  WIDTH  multiplier/divisor (from register-file rd2).
- hilo_we  input  1  MTHI/MTLO write strobe.
- hilo_sel  input  1  0 writes LO, 1 writes HI.
- hilo_wd  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in progress; control stalls on it.
- done  output  1  one-cycle pulse: HI/LO hold a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and working registers cleared. Reset mid-operation aborts it; no HI/LO update occurs.
- States:
  - IDLE -> CALC on start=1.
  - CALC stays for ITER edges, then -> FIX.
  - FIX -> IDLE after one edge.
- busy = (state != IDLE). It is derived from registered state only; it has no combinational path from start.
- Latency:
  - Edge E0 samples start (operands and op are latched at E0; they may change afterwards).
  - Edges E1..E32 perform the iterations.
  - Edge E33 writes HI/LO and returns to IDLE.
  - done=1 for exactly the cycle after E33; busy=1 from after E0 through E33.
- Back-to-back: start may be asserted in the done cycle; it is accepted, and done is still 1 that cycle.
- start while busy=1 is ignored. hilo_we while busy=1 is ignored.
- start and hilo_we in the same idle cycle: start wins and the HI/LO write is discarded.
- hilo_we in IDLE with no start: the selected register takes hilo_wd at that edge; done is not asserted.
- Signed ops (MULT, DIV): operands are converted to magnitudes at E0 and the result sign is corrected in FIX.
  - Product sign = sign_a XOR sign_b.
  - Quotient sign = sign_a XOR sign_b.
  - Remainder takes the sign of the dividend (truncating division).
- Multiply: shift-add, 1 bit per cycle; 64-bit product with HI = bits 63:32, LO = bits 31:0.
- Divide: restoring, 1 quotient bit per cycle; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = src_a unchanged. Normal latency applies.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- No exceptions are raised.

Decomposition:
- Shared package:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encodings IDLE, CALC, FIX.
  - ITER constant.
- One sub-module is natural: mdu_div_core.
  - Performs one restoring-division step: partial remainder, divisor, next quotient bit.
  - The multiply shift-add stays inline in mul_div_unit.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after E33: hi=0xFFFFFFFE, lo=0x00000001; done high one cycle; busy high 33 cycles.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 2×3, change src_a/src_b and pulse start at E5 -> second start ignored; result hi=0, lo=6.
- Idle hilo_we=1, hilo_sel=1, hilo_wd=0x1234 -> hi=0x1234 next edge, lo unchanged, done=0. Same cycle as start -> write discarded.
- Start DIVU 100/7, assert rst_n=0 at E10 -> hi=lo=0, busy=0, done=0 immediately. After release, DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  // Iteration cycles per operation (one bit per cycle over a 32-bit operand).
  localparam int ITER = 32;

  // Operation select as presented by control.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // True for DIV/DIVU.
  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the two's-complement variants (MULT/DIV).
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not borrow.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_in_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Trial subtraction; the MSB of the (WIDTH+1)-bit difference is the borrow.
  always_comb begin
    w_shift = {i_rem, i_in_bit};
    w_diff  = w_shift - {1'b0, i_divisor};
    if (w_diff[WIDTH] == 1'b0) begin
      o_rem  = w_diff[WIDTH-1:0];
      o_qbit = 1'b1;
    end else begin
      o_rem  = w_shift[WIDTH-1:0];
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated one bit per
// cycle in a shared 2*WIDTH register, and sign-corrected in the FIX state.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = mul_div_unit_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_hilo_we,
  input  logic             i_hilo_sel,
  input  logic [WIDTH-1:0] i_hilo_wd,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(ITER);

  state_e             r_state;
  op_e                r_op;
  logic [CW-1:0]      r_cnt;
  // Multiply: {accumulator, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a_raw;    // original dividend for divide-by-zero
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_in_div;
  logic               w_in_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .i_rem     (r_prod[2*WIDTH-1:WIDTH]),
    .i_in_bit  (r_prod[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_qbit    (w_qbit)
  );

  // Operand decode/magnitude and next-iteration values for both datapaths.
  always_comb begin
    w_in_div    = is_div(i_op);
    w_in_signed = is_signed_op(i_op);
    w_a_mag     = (w_in_signed && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
    w_b_mag     = (w_in_signed && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;
    w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    if (r_prod[0]) begin
      w_mul_next = {w_sum, r_prod[WIDTH-1:1]};
    end else begin
      w_mul_next = {1'b0, r_prod[2*WIDTH-1:1]};
    end
    w_div_next = {w_div_rem, r_prod[WIDTH-2:0], w_qbit};
  end

  // Sign correction and special cases applied when leaving the iteration loop.
  always_comb begin
    w_prod_fix = r_neg_q ? -r_prod : r_prod;
    if (!is_div(r_op)) begin
      w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end else if (r_div0) begin
      w_hi_fix = r_a_raw;
      w_lo_fix = {WIDTH{1'b1}};
    end else begin
      w_hi_fix = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    end
  end

  // Sequencer, iteration datapath and HI/LO register updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_MULT;
      r_cnt   <= {CW{1'b0}};
      r_prod  <= {(2*WIDTH){1'b0}};
      r_opnd  <= {WIDTH{1'b0}};
      r_a_raw <= {WIDTH{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // start takes priority; a simultaneous HI/LO write is dropped.
          if (i_start) begin
            r_state <= CALC;
            r_op    <= op_e'(i_op);
            r_cnt   <= {CW{1'b0}};
            r_prod  <= {{WIDTH{1'b0}}, (w_in_div ? w_a_mag : w_b_mag)};
            r_opnd  <= w_in_div ? w_b_mag : w_a_mag;
            r_a_raw <= i_src_a;
            r_neg_q <= w_in_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
            r_neg_r <= w_in_signed & i_src_a[WIDTH-1];
            r_div0  <= w_in_div & (i_src_b == {WIDTH{1'b0}});
          end else if (i_hilo_we) begin
            if (i_hilo_sel) begin
              r_hi <= i_hilo_wd;
            end else begin
              r_lo <= i_hilo_wd;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_prod <= is_div(r_op) ? w_div_next : w_mul_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= FIX;
          end else begin
            r_state <= CALC;
          end
        end
        FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] hilo_wd = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_src_a    (src_a),
    .i_src_b    (src_b),
    .i_hilo_we  (hilo_we),
    .i_hilo_sel (hilo_sel),
    .i_hilo_wd  (hilo_wd),
    .o_busy     (busy),
    .o_done     (done),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Launches one op from the current cycle (#1 after an edge) and returns in the done cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int poke_at, input logic we_too);
    exp_t e;
    exp_t got;
    int   n;
    logic held;
    e.tag = tag;
    e.hi  = ehi;
    e.lo  = elo;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (we_too) begin
      hilo_we  = 1'b1;
      hilo_sel = 1'b1;
      hilo_wd  = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_we = 1'b0;
    src_a   = $urandom;
    src_b   = $urandom;
    op      = 2'($urandom_range(0, 3));
    check($sformatf("%s_e0_hilo", tag), {hi, lo}, {m_hi, m_lo});
    n    = 0;
    held = 1'b1;
    while (busy && n < 100) begin
      if ({hi, lo} !== {m_hi, m_lo}) held = 1'b0;
      if (poke_at > 0 && n == poke_at) begin
        start    = 1'b1;
        op       = OP_MULTU;
        src_a    = 32'd9;
        src_b    = 32'd9;
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        hilo_wd  = 32'h5555_5555;
      end else begin
        start   = 1'b0;
        hilo_we = 1'b0;
      end
      n++;
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    hilo_we = 1'b0;
    check($sformatf("%s_busy_cycles", tag), 64'(n), 64'd33);
    check($sformatf("%s_held", tag), {63'd0, held}, 64'd1);
    check($sformatf("%s_done", tag), {63'd0, done}, 64'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check($sformatf("%s_hilo", got.tag), {hi, lo}, {got.hi, got.lo});
      m_hi = got.hi;
      m_lo = got.lo;
    end else begin
      check("scoreboard_empty", 64'(sb.size()), 64'd1);
    end
  endtask

  initial begin
    #12;
    check("reset_ctrl", {62'd0, busy, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step(1);

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
    step(1);
    check("done_one_cycle", {62'd0, busy, done}, 64'd0);

    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
    step(2);
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    // issued in the done cycle of the previous op
    do_op("divu_b2b", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0, 1'b0);
    step(1);
    do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 1'b0);
    step(1);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1'b0);
    step(1);
    do_op("div_neg_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 1'b0);
    step(1);
    do_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 1'b0);
    step(1);
    do_op("mult_ext", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 0, 1'b0);
    step(1);
    do_op("multu_poke", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1'b0);
    step(2);

    hilo_we  = 1'b1;
    hilo_sel = 1'b1;
    hilo_wd  = 32'h0000_1234;
    step(1);
    hilo_we = 1'b0;
    check("mthi_hilo", {hi, lo}, {32'h0000_1234, m_lo});
    check("mthi_done", {63'd0, done}, 64'd0);
    m_hi = 32'h0000_1234;
    hilo_we  = 1'b1;
    hilo_sel = 1'b0;
    hilo_wd  = 32'h0000_ABCD;
    step(1);
    hilo_we = 1'b0;
    check("mtlo_hilo", {hi, lo}, {m_hi, 32'h0000_ABCD});
    m_lo = 32'h0000_ABCD;
    step(1);
    do_op("start_vs_we", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b1);
    step(1);

    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    step(1);
    start = 1'b0;
    step(9);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {62'd0, busy, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    step(1);
    rst_n = 1'b1;
    step(1);
    check("post_reset_ctrl", {62'd0, busy, done}, 64'd0);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
